// File: rtl/gpo_pkg.sv
// Shared constants and types for the gpo_port general-purpose output peripheral.
package gpo_pkg;

  localparam logic [1:0] ADDR_ODR   = 2'd0;
  localparam logic [1:0] ADDR_BSR   = 2'd1;
  localparam logic [1:0] ADDR_TGL   = 2'd2;
  localparam logic [1:0] ADDR_PULSE = 2'd3;

  localparam int BSR_CLR_LSB    = 16;
  localparam int PULSE_LEN_LSB  = 16;
  localparam int PULSE_BUSY_BIT = 15;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } pulse_state_t;

endpackage

// File: rtl/gpo_pulse_timer.sv
// One-shot pulse engine: holds a pin mask active for a programmed number of clocks.
//   state  | meaning
//   IDLE   | no inversion applied; waits for a start with non-zero mask and length
//   ACTIVE | inversion applied; pcnt counts down, returns to IDLE when it reaches 1
module gpo_pulse_timer
  import gpo_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] mask,
  input  logic [CNT_W-1:0] len,
  output logic             active,
  output logic [WIDTH-1:0] pmask,
  output logic [CNT_W-1:0] pcnt
);

  pulse_state_t     state_q, state_d;
  logic [WIDTH-1:0] pmask_q, pmask_d;
  logic [CNT_W-1:0] pcnt_q,  pcnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pmask_q <= '0;
      pcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pmask_q <= pmask_d;
      pcnt_q  <= pcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pmask_d = pmask_q;
    pcnt_d  = pcnt_q;
    case (state_q)
      IDLE: begin
        if (start && (len != '0) && (mask != '0)) begin
          state_d = ACTIVE;
          pmask_d = mask;
          pcnt_d  = len;
        end
      end
      ACTIVE: begin
        // Terminal count at 1 so the counter never wraps; starts while busy are dropped.
        if (pcnt_q == CNT_W'(1)) begin
          state_d = IDLE;
          pcnt_d  = '0;
        end else begin
          pcnt_d = pcnt_q - CNT_W'(1);
        end
      end
    endcase
  end

  assign active = (state_q == ACTIVE);
  assign pmask  = pmask_q;
  assign pcnt   = pcnt_q;

endmodule

// File: rtl/gpo_port.sv
// Memory-mapped output port: ODR with set/clear and toggle writes, plus a pulse
// engine whose mask is XORed onto the pins while it runs.
module gpo_port
  import gpo_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ce,
  input  logic             wr_en,
  input  logic [1:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [WIDTH-1:0] outPort,
  output logic             pulse_busy
);

  logic [WIDTH-1:0] odr_q, odr_d;
  logic             wr;
  logic             pulse_start;
  logic             active;
  logic [WIDTH-1:0] pmask;
  logic [CNT_W-1:0] pcnt;
  logic [15:0]      pcnt_ext;
  logic [WIDTH-1:0] bsr_set, bsr_clr;

  assign wr          = ce & wr_en;
  assign pulse_start = wr && (addr == ADDR_PULSE);
  assign bsr_set     = wdata[WIDTH-1:0];
  assign bsr_clr     = wdata[BSR_CLR_LSB +: WIDTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) odr_q <= '0;
    else          odr_q <= odr_d;
  end

  always_comb begin
    odr_d = odr_q;
    if (wr) begin
      case (addr)
        ADDR_ODR: odr_d = wdata[WIDTH-1:0];
        // Clear first, then set, so set wins on a bit named in both fields.
        ADDR_BSR: odr_d = (odr_q & ~bsr_clr) | bsr_set;
        ADDR_TGL: odr_d = odr_q ^ wdata[WIDTH-1:0];
        default:  odr_d = odr_q;
      endcase
    end
  end

  gpo_pulse_timer #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_pulse_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (pulse_start),
    .mask    (wdata[WIDTH-1:0]),
    .len     (wdata[PULSE_LEN_LSB +: CNT_W]),
    .active  (active),
    .pmask   (pmask),
    .pcnt    (pcnt)
  );

  assign pcnt_ext = 16'(pcnt);

  always_comb begin
    rdata = '0;
    if (ce && !wr_en) begin
      case (addr)
        ADDR_ODR: rdata[WIDTH-1:0] = odr_q;
        ADDR_PULSE: begin
          rdata[WIDTH-1:0]      = pmask;
          rdata[PULSE_BUSY_BIT] = active;
          rdata[31:16]          = pcnt_ext;
        end
        default: rdata = '0;
      endcase
    end
  end

  assign outPort    = odr_q ^ (active ? pmask : '0);
  assign pulse_busy = active;

endmodule
